stuff_serializer: RTL and testbench
===================================

// Module: stuff_serializer
// PURPOSE
// Parametrised bit-stuffing serial transmitter: buffers raw data bits in an
// internal FIFO and shifts them out at a programmable baud rate.
// - Inserts a complement bit after every run of RUN_LEN identical bits
//   (or after RUN_LEN ones only, in HDLC mode).
// - Sits between the frame/bit source and the line driver.
// - Adds three things: valid/ready backpressure, a reset, and a per-bit
//   stuffed-bit flag.
// PARAMETERS
// RUN_LEN      5   run length that triggers insertion of one stuffed bit (>=2)
// DEPTH        32  raw-bit FIFO depth in bits (power of 2, >=4)
// BAUD_W       8   width of baudrate input
// STUFF_ZEROS  1   1: stuff after runs of 1s or 0s; 0: stuff after runs of 1s only
// PORTS
// clk         in   1       rising-edge clock
// reset_n     in   1       asynchronous active-low reset
// in_valid    in   1       in_bit valid
// in_bit      in   1       raw data bit
// in_ready    out  1       FIFO can accept; push = in_valid & in_ready
// baudrate    in   BAUD_W  clocks per line bit; 0 treated as 1
// txout       out  1       serial line bit
// txi         out  1       idle: 1 when nothing is being transmitted
// stuffed     out  1       1 while txout carries an inserted (stuffed) bit
// bit_strobe  out  1       1-cycle pulse on the first cycle of each line bit
// BEHAVIOUR
// - Reset (async, any time): FIFO flushed, state IDLE, run counter cleared,
//   baud counter cleared.
//   Outputs: txout=0, txi=1, stuffed=0, bit_strobe=0, in_ready=1.
// - FIFO: count width $clog2(DEPTH+1). in_ready = (count<DEPTH), no
//   combinational path from in_valid. Push and pop on the same edge are
//   allowed; count stays unchanged. Order is strictly preserved and no bit
//   is ever dropped.
// - States: IDLE, DATA, STUFF. All outputs are registered.
// - IDLE: txi=1, txout=0. On an edge with count>0: pop the head, go to DATA,
//   txout<=head, txi<=0, bit_strobe<=1.
//   Latency: a bit pushed into an empty FIFO at edge N appears on txout at
//   edge N+1.
// - Bit period: baudrate is latched at the start of each line bit as
//   P=max(baudrate,1). txout holds for exactly P cycles. Changing baudrate
//   mid-bit affects only the next bit.
// - Run tracking: run_val and run_cnt (width $clog2(RUN_LEN+1)) update when
//   a DATA bit starts.
//   - Same value as run_val: run_cnt+1. Otherwise run_cnt=1, run_val=bit.
//   - If STUFF_ZEROS=0, a 0 bit sets run_cnt=0.
// - End of a DATA period:
//   - run_cnt==RUN_LEN: go to STUFF. Drive ~run_val, stuffed=1.
//     - STUFF_ZEROS=1: run_cnt=1, run_val=~run_val.
//     - STUFF_ZEROS=0: run_cnt=0.
//   - Else if count>0: go to DATA with the next bit, back-to-back with no
//     gap cycle.
//   - Else: go to IDLE.
// - End of a STUFF period: count>0 -> DATA; else IDLE. A stuffed bit is
//   always sent, even when the run ends on the last buffered bit.
// - Entering IDLE clears the run counter, so runs never span an idle gap.
// - bit_strobe pulses on the first cycle of every DATA and STUFF period.
// - stuffed is valid for the whole STUFF period and is 0 otherwise.
// TESTING
// - STUFF_ZEROS=0, baud=1, push 1111110:
//   -> txout 1,1,1,1,1,0(stuffed),1,0; then txi=1.
//   stuffed is high for exactly 1 cycle.
// - STUFF_ZEROS=1, baud=1, push 00000 then stop:
//   -> txout 0,0,0,0,0,1(stuffed), then txi=1 and txout=0.
// - baud=4, push 101 -> each bit held 4 cycles, bit_strobe every 4th cycle.
//   Repeat with baud=0 -> identical to baud=1.
// - DEPTH=32, baud=8, in_valid held high with 40 bits:
//   -> in_ready drops once 32 bits are held and recovers as bits drain.
//   Output equals input plus correct stuffing; no loss or duplication.
// - Assert reset_n low mid-way through a stuffed bit:
//   -> outputs immediately take their reset values; in_ready=1.
//   A new frame 11111 then sends its stuffed 0 only after the 5th bit.
// - Push 111, let the FIFO drain to IDLE, then push 11:
//   -> no stuffed bit is sent (the run is cleared at IDLE).

Source files
------------

// File: rtl/stuff_serializer.sv
// stuff_serializer: FIFO-buffered bit-stuffing serial transmitter with programmable baud rate
module stuff_serializer #(
    parameter int RUN_LEN     = 5,
    parameter int DEPTH       = 32,
    parameter int BAUD_W      = 8,
    parameter int STUFF_ZEROS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    input  logic [BAUD_W-1:0] baudrate,
    output logic              txout,
    output logic              txi,
    output logic              stuffed,
    output logic              bit_strobe
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(RUN_LEN + 1);
    typedef enum logic [1:0] {IDLE, DATA, STUFF} state_t;
    state_t            state, nstate;
    logic [DEPTH-1:0]  mem;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [BAUD_W-1:0] cnt;
    logic [RW-1:0]     run_cnt, run_nxt;
    logic              run_val, push, pop, stuff_go, head, done;
    assign in_ready = count < CW'(DEPTH);
    assign push     = in_valid & in_ready;
    assign head     = mem[rd_ptr];
    assign done     = cnt == '0;
    assign run_nxt  = (STUFF_ZEROS == 0 && !head) ? '0 :
                      (head == run_val) ? run_cnt + RW'(1) : RW'(1);
    always_comb begin
        nstate   = state;
        pop      = 1'b0;
        stuff_go = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                nstate = DATA;
                pop    = 1'b1;
            end
            DATA: if (done) begin
                if (run_cnt == RW'(RUN_LEN)) begin
                    nstate   = STUFF;
                    stuff_go = 1'b1;
                end else if (count != '0) pop = 1'b1;
                else nstate = IDLE;
            end
            STUFF: if (done) begin
                if (count != '0) begin
                    nstate = DATA;
                    pop    = 1'b1;
                end else nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_bit;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cnt        <= '0;
            run_cnt    <= '0;
            run_val    <= 1'b0;
            txout      <= 1'b0;
            txi        <= 1'b1;
            stuffed    <= 1'b0;
            bit_strobe <= 1'b0;
        end else begin
            state      <= nstate;
            wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count      <= count + CW'(push) - CW'(pop);
            cnt        <= (pop | stuff_go) ? ((baudrate == '0) ? '0 : baudrate - BAUD_W'(1)) :
                          done ? cnt : cnt - BAUD_W'(1);
            bit_strobe <= pop | stuff_go;
            txout      <= pop ? head : stuff_go ? ~run_val : (nstate == IDLE) ? 1'b0 : txout;
            txi        <= nstate == IDLE;
            stuffed    <= nstate == STUFF;
            // the stuffed bit restarts the run with its own value only when zeros are tracked too
            if (pop) begin
                run_cnt <= run_nxt;
                run_val <= head;
            end else if (stuff_go) begin
                run_cnt <= (STUFF_ZEROS != 0) ? RW'(1) : '0;
                run_val <= (STUFF_ZEROS != 0) ? ~run_val : run_val;
            end else if (nstate == IDLE) run_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_stuff_serializer.sv
// tb_stuff_serializer: table-driven and directed checks of stuff_serializer
module tb_stuff_serializer;
    logic clk = 0, reset_n = 0, v1 = 0, v0 = 0, in_bit = 0;
    logic [7:0] baud = 8'd1;
    logic r1, t1, i1, s1, b1, r0, t0, i0, s0, b0;
    int checks = 0, errors = 0, cyc = 0;

    stuff_serializer #(.RUN_LEN(5), .DEPTH(32), .BAUD_W(8), .STUFF_ZEROS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_bit(in_bit), .in_ready(r1),
        .baudrate(baud), .txout(t1), .txi(i1), .stuffed(s1), .bit_strobe(b1));
    stuff_serializer #(.RUN_LEN(5), .DEPTH(32), .BAUD_W(8), .STUFF_ZEROS(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(v0), .in_bit(in_bit), .in_ready(r0),
        .baudrate(baud), .txout(t0), .txi(i0), .stuffed(s0), .bit_strobe(b0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic cb1[256], cs1[256], cb0[256], cs0[256];
    int cc1[256], cc0[256];
    int n1 = 0, n0 = 0, sc1 = 0, sc0 = 0;
    logic low1 = 0;
    always @(negedge clk) begin
        if (b1 && n1 < 256) begin cb1[n1] = t1; cs1[n1] = s1; cc1[n1] = cyc; n1++; end
        if (b0 && n0 < 256) begin cb0[n0] = t0; cs0[n0] = s0; cc0[n0] = cyc; n0++; end
        if (s1) sc1++;
        if (s0) sc0++;
        if (!r1) low1 = 1;
    end

    typedef struct {
        bit         sz;
        logic [7:0] baud;
        int         n;
        logic [15:0] bits;
        int         en;
        logic [15:0] eb;
        logic [15:0] es;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push(input bit sel, input bit b);
        int t = 0;
        @(negedge clk);
        while (!(sel ? r1 : r0) && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) chk("push_timeout", 1, 0);
        in_bit = b;
        if (sel) v1 = 1; else v0 = 1;
        @(posedge clk);
        #1 v1 = 0; v0 = 0;
    endtask

    task automatic wait_idle(input bit sel);
        int t = 0;
        @(negedge clk);
        while (!(sel ? i1 : i0) && t < 3000) begin @(negedge clk); t++; end
        if (t >= 3000) chk("idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic collect(input bit sel, input int base, input int p,
                           output logic [63:0] ob, output logic [63:0] os, output int on, output int badp);
        logic b, s;
        int c, cp;
        on = (sel ? n1 : n0) - base; ob = 0; os = 0; badp = 0; cp = 0;
        for (int k = 0; k < on; k++) begin
            b = sel ? cb1[base+k] : cb0[base+k];
            s = sel ? cs1[base+k] : cs0[base+k];
            c = sel ? cc1[base+k] : cc0[base+k];
            ob = {ob[62:0], b};
            os = {os[62:0], s};
            if (k > 0 && c - cp != p) badp++;
            cp = c;
        end
    endtask

    task automatic model(input logic [63:0] bits, input int n,
                         output logic [63:0] ob, output logic [63:0] os, output int on);
        int run = 0;
        logic val = 0, b;
        ob = 0; os = 0; on = 0;
        for (int i = 0; i < n; i++) begin
            b = bits[n-1-i];
            ob = {ob[62:0], b}; os = {os[62:0], 1'b0}; on++;
            run = (run > 0 && b == val) ? run + 1 : 1;
            val = b;
            if (run == 5) begin
                ob = {ob[62:0], ~b}; os = {os[62:0], 1'b1}; on++;
                run = 1; val = ~b;
            end
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        logic [63:0] ob, os;
        int on, badp, base, sbase, p;
        base = v.sz ? n1 : n0;
        sbase = v.sz ? sc1 : sc0;
        p = (v.baud == 0) ? 1 : int'(v.baud);
        baud = v.baud;
        for (int i = 0; i < v.n; i++) push(v.sz, v.bits[v.n-1-i]);
        wait_idle(v.sz);
        collect(v.sz, base, p, ob, os, on, badp);
        chk({nm, "_len"}, on, v.en);
        chk({nm, "_bits"}, ob, 64'(v.eb));
        chk({nm, "_stuffed"}, os, 64'(v.es));
        chk({nm, "_period"}, badp, 0);
        chk({nm, "_stuff_cycles"}, (v.sz ? sc1 : sc0) - sbase, $countones(v.es) * p);
        chk({nm, "_idle_line"}, {v.sz ? t1 : t0, v.sz ? i1 : i0}, 2'b01);
    endtask

    initial begin
        logic [63:0] ob, os, mb, ms;
        logic [39:0] pat;
        int on, mn, badp, base, t;
        vecs[0] = '{1'b0, 8'd1, 7,  16'b1111110,    8,  16'b11111010,     16'b00000100};
        vecs[1] = '{1'b1, 8'd1, 5,  16'b00000,      6,  16'b000001,       16'b000001};
        vecs[2] = '{1'b1, 8'd4, 3,  16'b101,        3,  16'b101,          16'b000};
        vecs[3] = '{1'b1, 8'd0, 3,  16'b101,        3,  16'b101,          16'b000};
        vecs[4] = '{1'b1, 8'd1, 5,  16'b11111,      6,  16'b111110,       16'b000001};
        vecs[5] = '{1'b1, 8'd2, 10, 16'b1111100000, 12, 16'b111110000010, 16'b000001000010};
        vecs[6] = '{1'b0, 8'd3, 6,  16'b000001,     6,  16'b000001,       16'b000000};
        vecs[7] = '{1'b0, 8'd1, 5,  16'b11111,      6,  16'b111110,       16'b000001};
        vecs[8] = '{1'b1, 8'd1, 7,  16'b0101110,    7,  16'b0101110,      16'b0000000};
        repeat (3) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        chk("rst_txout", t1, 0);
        chk("rst_txi", i1, 1);
        chk("rst_stuffed", s1, 0);
        chk("rst_strobe", b1, 0);
        chk("rst_in_ready", r1, 1);
        for (int i = 0; i < 9; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // single bit: latency of one edge, then straight back to idle
        baud = 1;
        @(negedge clk);
        in_bit = 1; v1 = 1;
        @(posedge clk);
        #1 v1 = 0;
        chk("lat_not_yet", {t1, i1}, 2'b01);
        @(posedge clk);
        #1 chk("lat_first", {b1, t1, i1}, 3'b110);
        @(posedge clk);
        #1 chk("lat_back_idle", {t1, i1}, 2'b01);
        repeat (2) @(negedge clk);

        // run cleared at idle
        run_vec("drain_a", '{1'b1, 8'd1, 3, 16'b111, 3, 16'b111, 16'b000});
        run_vec("drain_b", '{1'b1, 8'd1, 2, 16'b11,  2, 16'b11,  16'b00});

        // backpressure with 40 bits at baud 8
        pat = 40'hFC0F_8FF0_5A;
        baud = 8;
        base = n1;
        for (int i = 0; i < 40; i++) push(1, pat[39-i]);
        chk("bp_in_ready_dropped", low1, 1);
        wait_idle(1);
        collect(1, base, 8, ob, os, on, badp);
        model(64'(pat), 40, mb, ms, mn);
        chk("bp_len", on, mn);
        chk("bp_bits", ob, mb);
        chk("bp_stuffed", os, ms);
        chk("bp_period", badp, 0);
        chk("bp_in_ready_back", r1, 1);

        // asynchronous reset in the middle of a stuffed bit
        baud = 4;
        for (int i = 0; i < 5; i++) push(1, 1'b1);
        t = 0;
        @(negedge clk);
        while (!s1 && t < 200) begin @(negedge clk); t++; end
        chk("rst_mid_saw_stuff", s1, 1);
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("arst_txout", t1, 0);
        chk("arst_txi", i1, 1);
        chk("arst_stuffed", s1, 0);
        chk("arst_strobe", b1, 0);
        chk("arst_in_ready", r1, 1);
        @(negedge clk);
        reset_n = 1;
        run_vec("post_rst", '{1'b1, 8'd1, 5, 16'b11111, 6, 16'b111110, 16'b000001});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
